// File: rtl/sprite_draw_scheduler.sv
// Round-robin scheduler sharing one VGA pixel-write port among four sprite requesters.
// Each job erases the requester's previous box (if it moved), then draws the new one.
module sprite_draw_scheduler #(
    parameter int BOX_W = 12,
    parameter int BOX_H = 4,
    parameter int SCR_W = 160,
    parameter int SCR_H = 120
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  req_i,
    input  logic [31:0] req_x_i,
    input  logic [27:0] req_y_i,
    input  logic [11:0] req_color_i,
    output logic [3:0]  grant_o,
    output logic [3:0]  done_o,
    output logic [7:0]  x_o,
    output logic [6:0]  y_o,
    output logic [2:0]  color_o,
    output logic        plot_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    localparam logic [3:0] PX_LAST = 4'(BOX_W - 1);
    localparam logic [3:0] PY_LAST = 4'(BOX_H - 1);
    localparam logic [8:0] SCR_W_L = 9'(SCR_W);
    localparam logic [7:0] SCR_H_L = 8'(SCR_H);

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  new_x_q, new_x_d;
    logic [6:0]  new_y_q, new_y_d;
    logic [2:0]  color_q, color_d;
    logic [3:0]  px_q, px_d;
    logic [3:0]  py_q, py_d;

    logic [7:0]  old_x_q [4];
    logic [6:0]  old_y_q [4];
    logic [3:0]  last_valid_q;

    logic [3:0]  grant_q, grant_d;
    logic [3:0]  done_q, done_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  out_color_q, out_color_d;
    logic        plot_q, plot_d;
    logic        busy_q, busy_d;

    logic [7:0]  slot_x [4];
    logic [6:0]  slot_y [4];
    logic [2:0]  slot_c [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
        assign slot_x[gi] = req_x_i[gi*8 +: 8];
        assign slot_y[gi] = req_y_i[gi*7 +: 7];
        assign slot_c[gi] = req_color_i[gi*3 +: 3];
    end

    // Round-robin pick: first asserted request at or after the pointer.
    logic       sel_found;
    logic [1:0] sel_idx;
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!sel_found && req_i[ptr_q + k[1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = ptr_q + k[1:0];
            end
        end
    end

    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [8:0] sum_x;
    logic [7:0] sum_y;
    logic       moved;

    always_comb begin
        base_x = (state_q == ERASE) ? old_x_q[idx_q] : new_x_q;
        base_y = (state_q == ERASE) ? old_y_q[idx_q] : new_y_q;
        sum_x  = {1'b0, base_x} + {5'd0, px_q};
        sum_y  = {1'b0, base_y} + {4'd0, py_q};
        moved  = last_valid_q[sel_idx] &&
                 ((old_x_q[sel_idx] != slot_x[sel_idx]) || (old_y_q[sel_idx] != slot_y[sel_idx]));
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        new_x_d     = new_x_q;
        new_y_d     = new_y_q;
        color_d     = color_q;
        px_d        = px_q;
        py_d        = py_q;
        grant_d     = 4'd0;
        done_d      = 4'd0;
        x_d         = x_q;
        y_d         = y_q;
        out_color_d = out_color_q;
        plot_d      = 1'b0;
        busy_d      = 1'b1;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // done_q high means the previous job's done cycle is still showing.
                if (sel_found && !done_q[idx_q]) begin
                    grant_d = 4'd1 << sel_idx;
                    busy_d  = 1'b1;
                    idx_d   = sel_idx;
                    ptr_d   = sel_idx + 2'd1;
                    new_x_d = slot_x[sel_idx];
                    new_y_d = slot_y[sel_idx];
                    color_d = slot_c[sel_idx];
                    px_d    = 4'd0;
                    py_d    = 4'd0;
                    state_d = moved ? ERASE : DRAW;
                end
            end
            ERASE, DRAW: begin
                x_d         = sum_x[7:0];
                y_d         = sum_y[6:0];
                out_color_d = (state_q == ERASE) ? 3'd0 : color_q;
                plot_d      = (sum_x < SCR_W_L) && (sum_y < SCR_H_L);
                if (px_q == PX_LAST) begin
                    px_d = 4'd0;
                    if (py_q == PY_LAST) begin
                        py_d    = 4'd0;
                        state_d = (state_q == ERASE) ? DRAW : DONE;
                    end else begin
                        py_d = py_q + 4'd1;
                    end
                end else begin
                    px_d = px_q + 4'd1;
                end
            end
            DONE: begin
                done_d  = 4'd1 << idx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            idx_q       <= 2'd0;
            new_x_q     <= 8'd0;
            new_y_q     <= 7'd0;
            color_q     <= 3'd0;
            px_q        <= 4'd0;
            py_q        <= 4'd0;
            grant_q     <= 4'd0;
            done_q      <= 4'd0;
            x_q         <= 8'd0;
            y_q         <= 7'd0;
            out_color_q <= 3'd0;
            plot_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            new_x_q     <= new_x_d;
            new_y_q     <= new_y_d;
            color_q     <= color_d;
            px_q        <= px_d;
            py_q        <= py_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            x_q         <= x_d;
            y_q         <= y_d;
            out_color_q <= out_color_d;
            plot_q      <= plot_d;
            busy_q      <= busy_d;
        end
    end

    // Position is committed only on completion, so an aborted job leaves no stale box record.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_valid_q <= 4'd0;
            for (int k = 0; k < 4; k++) begin
                old_x_q[k] <= 8'd0;
                old_y_q[k] <= 7'd0;
            end
        end else if (state_q == DONE) begin
            old_x_q[idx_q]      <= new_x_q;
            old_y_q[idx_q]      <= new_y_q;
            last_valid_q[idx_q] <= 1'b1;
        end
    end

    assign grant_o = grant_q;
    assign done_o  = done_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign color_o = out_color_q;
    assign plot_o  = plot_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Scoreboard bench for sprite_draw_scheduler: a job-level reference model fills
// expected grant/pixel/done queues; an independent monitor pops and compares.
module tb_sprite_draw_scheduler;

    localparam int BW = 12;
    localparam int BH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_i = 4'd0;
    logic [31:0] req_x_i = 32'd0;
    logic [27:0] req_y_i = 28'd0;
    logic [11:0] req_color_i = 12'd0;
    logic [3:0]  grant_o, done_o;
    logic [7:0]  x_o;
    logic [6:0]  y_o;
    logic [2:0]  color_o;
    logic        plot_o, busy_o;

    always #5 clk = ~clk;

    sprite_draw_scheduler dut (
        .clk_i(clk), .rst_i(rst), .req_i(req_i), .req_x_i(req_x_i),
        .req_y_i(req_y_i), .req_color_i(req_color_i), .grant_o(grant_o),
        .done_o(done_o), .x_o(x_o), .y_o(y_o), .color_o(color_o),
        .plot_o(plot_o), .busy_o(busy_o)
    );

    typedef struct {int x; int y; int c;} pix_t;
    typedef struct {int idx; int len; int nplot;} job_t;

    pix_t pix_q[$];
    job_t job_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int   m_ptr;
    bit   m_lv[4];
    int   m_ox[4];
    int   m_oy[4];
    int   lx[4];
    int   ly[4];
    int   lc[4];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic void push_box(input int bx, input int by, input int c, inout job_t j);
        pix_t p;
        for (int py = 0; py < BH; py++)
            for (int px = 0; px < BW; px++)
                if (bx + px < 160 && by + py < 120) begin
                    p.x = bx + px; p.y = by + py; p.c = c;
                    pix_q.push_back(p);
                    j.nplot++;
                end
    endfunction

    function automatic void model_job(input int i, input int x, input int y, input int c);
        job_t j;
        bit   er;
        er = m_lv[i] && (m_ox[i] != x || m_oy[i] != y);
        j.idx = i;
        j.nplot = 0;
        j.len = er ? 2 + 2 * BW * BH : 2 + BW * BH;
        if (er) push_box(m_ox[i], m_oy[i], 0, j);
        push_box(x, y, c, j);
        m_ox[i] = x;
        m_oy[i] = y;
        m_lv[i] = 1'b1;
        job_q.push_back(j);
    endfunction

    function automatic void model_reset();
        m_ptr = 0;
        for (int i = 0; i < 4; i++) m_lv[i] = 1'b0;
        pix_q.delete();
        job_q.delete();
    endfunction

    task automatic set_lane(input int i, input int x, input int y, input int c);
        req_x_i[i*8 +: 8]     = 8'(x);
        req_y_i[i*7 +: 7]     = 7'(y);
        req_color_i[i*3 +: 3] = 3'(c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_i = 4'd0;
        #1;
        check("reset_outputs", int'({grant_o, done_o, x_o, y_o, color_o, plot_o, busy_o}), 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Model predicts the round-robin order for a held request mask; rereq re-raises lane 0 when lane 3 is granted.
    task automatic run_batch(input logic [3:0] mask, input bit rereq, input int rx, input int ry, input int rc);
        logic [3:0] m;
        int total, dones, t;
        m = mask;
        total = rereq ? 1 : 0;
        while (m != 4'd0) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (m[i]) begin
                    model_job(i, lx[i], ly[i], lc[i]);
                    m[i] = 1'b0;
                    m_ptr = (i + 1) % 4;
                    total++;
                    break;
                end
            end
        end
        if (rereq) begin
            model_job(0, rx, ry, rc);
            m_ptr = 1;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_lane(i, lx[i], ly[i], lc[i]);
        req_i = mask;
        dones = 0;
        t = 0;
        while (dones < total && t < 3000) begin
            @(negedge clk);
            t++;
            if (rereq && grant_o[3]) begin
                set_lane(0, rx, ry, rc);
                req_i[0] = 1'b1;
            end
            req_i = req_i & ~grant_o;
            if (done_o != 4'd0) dones++;
        end
        if (t >= 3000) check("batch_timeout_dones", dones, total);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: decoupled from stimulus, compares DUT activity against the queues.
    int   mon_cyc = 0;
    int   mon_gcyc = 0;
    int   mon_seen = 0;
    bit   mon_active = 1'b0;
    job_t mon_cur;
    pix_t mon_p;

    initial begin
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (rst) begin
                mon_active = 1'b0;
                continue;
            end
            if (grant_o != 4'd0) begin
                if (job_q.size() == 0) check("unexpected_grant", int'(grant_o), 0);
                else begin
                    mon_cur = job_q.pop_front();
                    check("grant_onehot", int'(grant_o), 1 << mon_cur.idx);
                    check("busy_at_grant", int'(busy_o), 1);
                    mon_active = 1'b1;
                    mon_gcyc = mon_cyc;
                    mon_seen = 0;
                end
            end
            if (plot_o) begin
                if (pix_q.size() == 0) check("unexpected_plot", 1, 0);
                else begin
                    mon_p = pix_q.pop_front();
                    mon_seen++;
                    check("pixel_xyc", int'(x_o) * 1024 + int'(y_o) * 8 + int'(color_o),
                          mon_p.x * 1024 + mon_p.y * 8 + mon_p.c);
                end
            end
            if (done_o != 4'd0) begin
                if (!mon_active) check("unexpected_done", int'(done_o), 0);
                else begin
                    check("done_onehot", int'(done_o), 1 << mon_cur.idx);
                    check("job_length", mon_cyc - mon_gcyc + 1, mon_cur.len);
                    check("plot_count", mon_seen, mon_cur.nplot);
                    check("busy_at_done", int'(busy_o), 1);
                    $display("job lane %0d: %0d cycles, %0d pixels plotted", mon_cur.idx, mon_cyc - mon_gcyc + 1, mon_seen);
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        int t;
        model_reset();
        for (int i = 0; i < 4; i++) begin lx[i] = 0; ly[i] = 0; lc[i] = 0; end
        repeat (3) @(negedge clk);
        check("reset_outputs_init", int'({grant_o, done_o, x_o, y_o, color_o, plot_o, busy_o}), 0);
        rst = 1'b0;

        // First draw, then a move that erases the old box.
        lx[0] = 14; ly[0] = 99; lc[0] = 7;
        run_batch(4'b0001, 1'b0, 0, 0, 0);
        lx[0] = 54;
        run_batch(4'b0001, 1'b0, 0, 0, 0);

        // All four from a fresh pointer, lane 0 re-raised while lane 3 runs.
        do_reset();
        lx[0] = 10;  ly[0] = 5;   lc[0] = 1;
        lx[1] = 40;  ly[1] = 20;  lc[1] = 2;
        lx[2] = 80;  ly[2] = 60;  lc[2] = 3;
        lx[3] = 120; ly[3] = 100; lc[3] = 4;
        run_batch(4'b1111, 1'b1, 30, 7, 5);

        // Same position, new colour: redraw only.
        lx[0] = 30; ly[0] = 7; lc[0] = 2;
        run_batch(4'b0001, 1'b0, 0, 0, 0);

        // Clipping at the bottom-right corner.
        lx[1] = 155; ly[1] = 118; lc[1] = 6;
        run_batch(4'b0010, 1'b0, 0, 0, 0);

        // Reset in the middle of an erase.
        model_job(1, 20, 20, 5);
        @(negedge clk);
        set_lane(1, 20, 20, 5);
        req_i = 4'b0010;
        t = 0;
        while (!grant_o[1] && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("midreset_grant_timeout", t, 0);
        req_i = 4'd0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("reset_mid_outputs", int'({grant_o, done_o, x_o, y_o, color_o, plot_o, busy_o}), 0);
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        lx[1] = 30; ly[1] = 40; lc[1] = 3;
        run_batch(4'b0010, 1'b0, 0, 0, 0);

        // Random batches.
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (m_lv[i] && $urandom_range(0, 3) == 0) begin
                    lx[i] = m_ox[i]; ly[i] = m_oy[i];
                end else begin
                    lx[i] = $urandom_range(0, 255); ly[i] = $urandom_range(0, 127);
                end
                lc[i] = $urandom_range(0, 7);
            end
            run_batch(4'($urandom_range(1, 15)), 1'b0, 0, 0, 0);
        end

        repeat (5) @(negedge clk);
        check("leftover_jobs", job_q.size(), 0);
        check("leftover_pixels", pix_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sprite_draw_scheduler.md
Name: sprite_draw_scheduler

Overview:
- Shares the single VGA pixel-write port among four sprite requesters: player box, enemy, two bullets.
- Each granted job erases the requester's previously drawn box (colour 000), then draws the box at the new position, one pixel per clock.
- Sits between the game-logic blocks (player lane loader, enemy/bullet movers) and the VGA adapter.
- Replaces ad-hoc direct drive of the adapter by individual box drawers.

Parameters:
- BOX_W, 12, box width in pixels (1..16)
- BOX_H, 4, box height in pixels (1..16)
- SCR_W, 160, screen width; pixels with x >= SCR_W are suppressed
- SCR_H, 120, screen height; pixels with y >= SCR_H are suppressed

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  4  per-requester draw request, level; held until matching grant
- req_x  in  32  flattened {x3,x2,x1,x0}, 8 bits each, box top-left x
- req_y  in  28  flattened {y3,y2,y1,y0}, 7 bits each, box top-left y
- req_color  in  12  flattened {c3,c2,c1,c0}, 3 bits each
- grant  out  4  one-hot, one-cycle pulse when a request is accepted
- done  out  4  one-hot, one-cycle pulse when that requester's job completes
- x_out  out  8  pixel x to VGA adapter
- y_out  out  7  pixel y to VGA adapter
- color_out  out  3  pixel colour
- plot  out  1  pixel write enable
- busy  out  1  high from grant cycle through done cycle

Behaviour:
- Reset (async, active-high):
  - All outputs 0; state IDLE; round-robin pointer = 0.
  - All four "last drawn" valid bits cleared.
  - Reset mid-job aborts immediately; no done pulse is issued.
- State machine: IDLE, ERASE, DRAW, DONE.
- IDLE:
  - Select the first asserted req starting from the pointer index, wrapping 3 -> 0.
  - In the same cycle: grant[i]=1; latch req_x/req_y/req_color slice i; set pointer = (i+1) mod 4; busy=1.
  - Next state is ERASE if last_valid[i] and the stored position differs from the new one; otherwise DRAW.
  - Same position with a different colour goes straight to DRAW (redraw only).
- ERASE:
  - Walk the stored old position, BOX_W*BOX_H cycles, colour 000.
  - Then go to DRAW with the pixel counters cleared.
- DRAW:
  - Walk the new position, BOX_W*BOX_H cycles, latched colour.
  - Then go to DONE.
- DONE (one cycle):
  - done[i]=1.
  - Store the new x/y into the old-position registers for i; last_valid[i]=1.
  - Next state is IDLE; busy deasserts in the IDLE cycle.
- Pixel walk:
  - Counters px (0..BOX_W-1) and py (0..BOX_H-1); px increments every cycle; at BOX_W-1 it wraps to 0 and py increments.
  - x_out = base_x + px (9-bit sum, truncated to 8 bits for output); y_out = base_y + py (8-bit sum, truncated to 7 bits).
  - plot=1 only when the untruncated sum satisfies x < SCR_W and y < SCR_H; clipped pixels still take their cycle, with plot=0.
- Timing:
  - Outputs are registered. The first plot occurs the cycle after grant.
  - Job length from grant to done is 1 + (erase ? 2 : 1) * BOX_W*BOX_H + 1 cycles.
  - Minimum gap between consecutive grants is 1 IDLE cycle.
- Requests:
  - req changes during a job are ignored until IDLE.
  - req/x/y/color are sampled only in the grant cycle.
  - A requester dropping req before grant is never granted.
- plot=0 in IDLE and DONE; x_out/y_out/color_out hold their last values.

Test Plan:
- Reset, then req[0]=1 with x0=14, y0=99, c0=111 -> grant[0] next edge. Bench sees 48 plots, x 14..25, y 99..102, colour 111 (no erase, first draw). Then done[0].
- Same requester re-requests x0=54 -> 48 plots colour 000 at x 14..25, then 48 plots colour 111 at x 54..65. done[0] on cycle 98 after grant.
- req=4'b1111 held from IDLE, pointer=0 -> grant order 0,1,2,3. A repeated req[0] while job 3 runs is granted next (pointer wrap).
- Re-request with identical position and new colour 010 -> no erase phase; 48 plots of 010.
- x=155, y=118 -> plot=1 only for x 155..159, y 118..119 (10 pixels). 48 walk cycles still elapse.
- Assert reset midway through ERASE -> all outputs 0 the same cycle, no done. Next request for that requester draws without erase.
